// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared definitions for the multi-channel ADC scan receiver.
//   state_t    - scan FSM state encoding
//   clog2      - ceiling log2 for elaboration-time widths
//   cnt_width  - width of a counter holding 0..n-1 (at least 1 bit)
//   ch_width   - channel-index width, max(1, clog2(NUM_CH))
//   nbits      - bits per SPI transfer (one full result word)
package adc_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_XFER,
    S_TACQ
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int ch_width(input int num_ch);
    return cnt_width(num_ch);
  endfunction

  function automatic int nbits(input int data_bits);
    return data_bits;
  endfunction

endpackage

// File: rtl/adc_scan_receiver_if.sv
// adc_scan_receiver_if: bundles the fabric-side control/result signals and
// the ADC pins of adc_scan_receiver.
//   slave  - the receiver: takes start/mask/config and SDO, drives results and
//            CONVST/SCK/SDI
//   master - the fabric plus ADC side: the opposite directions
interface adc_scan_receiver_if #(
  parameter int DATA_BITS = 12,
  parameter int CFG_BITS  = 6,
  parameter int NUM_CH    = 4
);
  localparam int CH_W = adc_scan_pkg::ch_width(NUM_CH);

  logic                       i_start;
  logic                       i_continuous;
  logic [NUM_CH-1:0]          i_ch_en;
  logic [NUM_CH*CFG_BITS-1:0] i_cfg;
  logic                       o_busy;
  logic                       o_rx_dv;
  logic [DATA_BITS-1:0]       o_rx_data;
  logic [CH_W-1:0]            o_rx_ch;
  logic                       o_scan_done;
  logic                       i_serial_rx;
  logic                       o_convst;
  logic                       o_sck;
  logic                       o_serial_tx;

  modport slave (
    input  i_start, i_continuous, i_ch_en, i_cfg, i_serial_rx,
    output o_busy, o_rx_dv, o_rx_data, o_rx_ch, o_scan_done,
           o_convst, o_sck, o_serial_tx
  );

  modport master (
    output i_start, i_continuous, i_ch_en, i_cfg, i_serial_rx,
    input  o_busy, o_rx_dv, o_rx_data, o_rx_ch, o_scan_done,
           o_convst, o_sck, o_serial_tx
  );
endinterface

// File: rtl/adc_spi_shifter.sv
// adc_spi_shifter: one full-duplex SPI transfer of DATA_BITS bits, MSB first.
// Each bit lasts 2*SCK_HALF clocks: SDI updates at phase 0, SCK rises and SDO
// is captured at phase SCK_HALF. SCK returns low at the end of the last bit.
//   clk, rst  - system clock, async active-high reset
//   start     - one-cycle pulse: load tx_word and begin a transfer
//   tx_word   - word to shift out on sdi
//   sdo       - ADC serial data in
//   done      - high during the final cycle of the transfer
//   rx_word   - captured word (complete by the time done is high)
//   sck, sdi  - registered SPI clock and data out
module adc_spi_shifter
  import adc_scan_pkg::*;
#(
  parameter int DATA_BITS = 12,
  parameter int SCK_HALF  = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_word,
  input  logic                 sdo,
  output logic                 done,
  output logic [DATA_BITS-1:0] rx_word,
  output logic                 sck,
  output logic                 sdi
);
  localparam int PH_W  = cnt_width(2 * SCK_HALF);
  localparam int BIT_W = cnt_width(DATA_BITS);

  logic                 active;
  logic [PH_W-1:0]      ph;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] tx_sr;
  logic [DATA_BITS-1:0] rx_sr;
  logic                 last_ph;
  logic                 last_bit;

  assign last_ph  = (ph == PH_W'(2 * SCK_HALF - 1));
  assign last_bit = (bit_idx == BIT_W'(DATA_BITS - 1));
  assign done     = active && last_ph && last_bit;
  assign rx_word  = rx_sr;

  // NOTE: the shift registers sit in the async reset with everything else so
  // an abandoned transfer leaves no stale bits; sequential state uses <= only
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      ph      <= '0;
      bit_idx <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck     <= 1'b0;
      sdi     <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      ph      <= '0;
      bit_idx <= '0;
      tx_sr   <= tx_word;
      sck     <= 1'b0;
      sdi     <= 1'b0;
    end else if (active) begin
      if (ph == '0) begin
        sck   <= 1'b0;
        sdi   <= tx_sr[DATA_BITS-1];
        tx_sr <= tx_sr << 1;
      end
      if (ph == PH_W'(SCK_HALF)) begin
        sck   <= 1'b1;
        rx_sr <= (rx_sr << 1) | DATA_BITS'(sdo);
      end
      if (last_ph) begin
        ph      <= '0;
        bit_idx <= bit_idx + 1'b1;
        if (last_bit) begin
          active <= 1'b0;
          sck    <= 1'b0;
          sdi    <= 1'b0;
        end
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_receiver.sv
// adc_scan_receiver: scans the enabled channels of an SPI multi-channel ADC.
// Each slot is CONV (CONVST high) -> XFER (config of the current channel out,
// result of the previous channel in) -> TACQ. The first transfer after IDLE
// only primes the pipeline; a final flush transfer collects the last result.
//   i_clk, i_rst - system clock, async active-high reset
//   bus          - slave modport: start/continuous/mask/config in, tagged
//                  results and busy out, ADC pins CONVST/SCK/SDI/SDO
module adc_scan_receiver
  import adc_scan_pkg::*;
#(
  parameter int DATA_BITS    = 12,
  parameter int CFG_BITS     = 6,
  parameter int NUM_CH       = 4,
  parameter int SCK_HALF     = 25,
  parameter int TCONV_CYCLES = 100,
  parameter int TACQ_CYCLES  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  adc_scan_receiver_if.slave  bus
);
  localparam int CH_W    = ch_width(NUM_CH);
  localparam int NBITS   = nbits(DATA_BITS);
  localparam int CNT_MAX = (TCONV_CYCLES > TACQ_CYCLES) ? TCONV_CYCLES : TACQ_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_CH-1:0]          mask;
  logic [NUM_CH*CFG_BITS-1:0] cfg_l;
  logic [CH_W-1:0]            cur_ch;     // channel whose config goes out now
  logic                       cur_flush;  // current transfer only collects
  logic                       pend_valid; // current transfer returns a result
  logic [CH_W-1:0]            pend_ch;
  logic                       pend_last;
  logic [CH_W-1:0]            nxt_ch;
  logic                       nxt_found;
  logic [CFG_BITS-1:0]        cur_cfg;
  logic [NBITS-1:0]           tx_word;
  logic [NBITS-1:0]           rx_word;
  logic                       xfer_start;
  logic                       xfer_done;
  logic                       conv_last;
  logic                       tacq_last;

  function automatic logic [CH_W-1:0] lowest_en(input logic [NUM_CH-1:0] m);
    lowest_en = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (m[c]) lowest_en = CH_W'(c);
  endfunction

  // Next enabled channel above cur_ch; none found means cur_ch ends the scan.
  // NOTE: outputs get a default first so no path through the loop infers a latch.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask[c] && (c > int'(cur_ch))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(c);
      end
    end
  end

  assign conv_last  = (cnt == CNT_W'(TCONV_CYCLES - 1));
  assign tacq_last  = (cnt == CNT_W'(TACQ_CYCLES - 1));
  assign xfer_start = (state == S_CONV) && conv_last;
  assign cur_cfg    = cfg_l[int'(cur_ch) * CFG_BITS +: CFG_BITS];
  // Config is left-aligned in the transfer; the trailing bits are sent as 0.
  assign tx_word    = NBITS'(cur_cfg) << (NBITS - CFG_BITS);

  adc_spi_shifter #(
    .DATA_BITS (NBITS),
    .SCK_HALF  (SCK_HALF)
  ) u_shifter (
    .clk     (i_clk),
    .rst     (i_rst),
    .start   (xfer_start),
    .tx_word (tx_word),
    .sdo     (bus.i_serial_rx),
    .done    (xfer_done),
    .rx_word (rx_word),
    .sck     (bus.o_sck),
    .sdi     (bus.o_serial_tx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      mask            <= '0;
      cfg_l           <= '0;
      cur_ch          <= '0;
      cur_flush       <= 1'b0;
      pend_valid      <= 1'b0;
      pend_ch         <= '0;
      pend_last       <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_convst    <= 1'b0;
      bus.o_rx_dv     <= 1'b0;
      bus.o_rx_data   <= '0;
      bus.o_rx_ch     <= '0;
      bus.o_scan_done <= 1'b0;
    end else begin
      bus.o_rx_dv     <= 1'b0;
      bus.o_scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start && (|bus.i_ch_en)) begin
            mask         <= bus.i_ch_en;
            cfg_l        <= bus.i_cfg;
            cur_ch       <= lowest_en(bus.i_ch_en);
            cur_flush    <= 1'b0;
            pend_valid   <= 1'b0;
            cnt          <= '0;
            state        <= S_CONV;
            bus.o_convst <= 1'b1;
            bus.o_busy   <= 1'b1;
          end
        end
        S_CONV: begin
          if (conv_last) begin
            state        <= S_XFER;
            bus.o_convst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (xfer_done) begin
            state <= S_TACQ;
            cnt   <= '0;
            if (pend_valid) begin
              bus.o_rx_dv     <= 1'b1;
              bus.o_rx_data   <= rx_word;
              bus.o_rx_ch     <= pend_ch;
              bus.o_scan_done <= pend_last;
            end
            // The next transfer returns the conversion configured just now.
            pend_valid <= 1'b1;
            pend_ch    <= cur_ch;
            pend_last  <= !nxt_found;
          end
        end
        S_TACQ: begin
          if (tacq_last) begin
            cnt <= '0;
            if (cur_flush) begin
              state      <= S_IDLE;
              bus.o_busy <= 1'b0;
            end else begin
              state        <= S_CONV;
              bus.o_convst <= 1'b1;
              if (nxt_found) begin
                cur_ch <= nxt_ch;
              end else if (bus.i_continuous && (|bus.i_ch_en)) begin
                // Wrap without re-priming: the pipeline is already full.
                mask   <= bus.i_ch_en;
                cfg_l  <= bus.i_cfg;
                cur_ch <= lowest_en(bus.i_ch_en);
              end else begin
                cur_ch    <= lowest_en(mask);
                cur_flush <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_receiver.sv
// Scoreboard bench for adc_scan_receiver. A behavioural ADC captures the
// config from SDI and answers the next conversion on SDO; expected strobes
// are queued by the stimulus and popped by an independent monitor.
module tb_adc_scan_receiver;
  localparam int DB    = 12;
  localparam int CB    = 6;
  localparam int NCH   = 4;
  localparam int TCONV = 4;
  localparam int SLOT  = TCONV + DB * 2 * 2 + 2;   // 54 cycles
  localparam int EV_RX = 0, EV_CONV = 1, EV_SCK = 2;

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] data;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_scan_receiver_if #(.DATA_BITS(DB), .CFG_BITS(CB), .NUM_CH(NCH)) bus ();

  adc_scan_receiver #(
    .DATA_BITS(DB), .CFG_BITS(CB), .NUM_CH(NCH),
    .SCK_HALF(2), .TCONV_CYCLES(TCONV), .TACQ_CYCLES(2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_vec = 0, n_err = 0;
  int   n_rx = 0, n_conv = 0, n_sck = 0, busy_cyc = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- ADC model ----------------
  function automatic logic [11:0] adc_value(input logic [5:0] cfg);
    if (cfg == 6'h2D) return 12'hA5C;
    return 12'h100 + {10'd0, cfg[1:0]};
  endfunction

  logic [11:0] adc_sr = '0, conv_res = '0;
  logic [5:0]  cap_cfg = '0, last_cfg = '0;
  logic [5:0]  cfg_hist[$];
  int          cap_bits = 0, hi_cnt = 0;
  logic        p_convst = 1'b0, p_sck = 1'b0;

  always @(negedge clk) begin
    if (bus.o_convst) hi_cnt++;
    if (bus.o_convst && !p_convst) begin
      conv_res = adc_value(last_cfg);
      cap_bits = 0;
      n_conv++;
    end
    if (!bus.o_convst && p_convst) begin
      check("convst_width", hi_cnt, TCONV);
      hi_cnt = 0;
      adc_sr = conv_res;
    end
    if (!bus.o_sck && p_sck) adc_sr = adc_sr << 1;
    if (bus.o_sck && !p_sck) begin
      n_sck++;
      if (cap_bits < CB) begin
        cap_cfg = {cap_cfg[4:0], bus.o_serial_tx};
        cap_bits++;
        if (cap_bits == CB) begin
          last_cfg = cap_cfg;
          cfg_hist.push_back(cap_cfg);
        end
      end
    end
    p_convst        = bus.o_convst;
    p_sck           = bus.o_sck;
    bus.i_serial_rx = adc_sr[11];
  end

  always @(negedge clk) if (bus.o_busy) busy_cyc++;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.o_rx_dv) begin
      exp_t e;
      n_rx++;
      check("strobe_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_ch", bus.o_rx_ch, e.ch);
        check("rx_data", bus.o_rx_data, e.data);
        check("scan_done", bus.o_scan_done, e.done);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [1:0] ch, input logic [11:0] data, input logic done);
    exp_t e;
    e.ch = ch; e.data = data; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.i_start = 1'b1;
    @(negedge clk) bus.i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.o_busy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("idle_reached", bus.o_busy, 0);
  endtask

  function automatic int ev_count(input int sel);
    case (sel)
      EV_RX:   return n_rx;
      EV_CONV: return n_conv;
      default: return n_sck;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int target);
    int g = 0;
    while (ev_count(sel) < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("event_wait", 64'(ev_count(sel) >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, strobes seen %0d", n_rx);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int b0, r0, c0, s0;
    bus.i_start = 1'b0; bus.i_continuous = 1'b0;
    bus.i_ch_en = '0;   bus.i_cfg = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {bus.o_busy, bus.o_rx_dv, bus.o_convst, bus.o_sck, bus.o_serial_tx,
           bus.o_scan_done, bus.o_rx_ch, bus.o_rx_data}, 0);

    // 1: single channel, cfg 2D, ADC answers A5C
    bus.i_ch_en = 4'b0001; bus.i_cfg = {18'd0, 6'h2D};
    cfg_hist.delete(); b0 = busy_cyc; r0 = n_rx; c0 = n_conv;
    push_exp(2'd0, 12'hA5C, 1'b1);
    pulse_start(); wait_idle();
    check("single_conversions", n_conv - c0, 2);
    check("single_strobes", n_rx - r0, 1);
    check("single_busy_cycles", busy_cyc - b0, 2 * SLOT);
    check("single_sdi_count", cfg_hist.size(), 2);
    foreach (cfg_hist[i]) check("single_sdi_cfg", cfg_hist[i], 6'h2D);

    // 2: sparse mask 1010, results 0x100+ch
    bus.i_ch_en = 4'b1010; bus.i_cfg = {6'h13, 6'h12, 6'h11, 6'h10};
    b0 = busy_cyc; c0 = n_conv;
    push_exp(2'd1, 12'h101, 1'b0);
    push_exp(2'd3, 12'h103, 1'b1);
    pulse_start(); wait_idle();
    check("sparse_conversions", n_conv - c0, 3);
    check("sparse_busy_cycles", busy_cyc - b0, 3 * SLOT);

    // 3: continuous on mask 0011 for five strobes, then the flush
    bus.i_ch_en = 4'b0011; bus.i_continuous = 1'b1;
    b0 = busy_cyc; r0 = n_rx;
    for (int k = 0; k < 3; k++) begin
      push_exp(2'd0, 12'h100, 1'b0);
      push_exp(2'd1, 12'h101, 1'b1);
    end
    pulse_start();
    wait_evt(EV_RX, r0 + 5);
    bus.i_continuous = 1'b0;
    wait_idle();
    check("cont_strobes", n_rx - r0, 6);
    check("cont_busy_cycles", busy_cyc - b0, 7 * SLOT);

    // 4a: zero mask start is ignored
    bus.i_ch_en = 4'b0000; b0 = busy_cyc;
    pulse_start();
    repeat (3) @(negedge clk);
    check("zero_mask_busy", busy_cyc - b0, 0);

    // 4b: start pulsed during XFER is ignored
    bus.i_ch_en = 4'b0001; bus.i_cfg = {18'd0, 6'h2D};
    b0 = busy_cyc; r0 = n_rx;
    push_exp(2'd0, 12'hA5C, 1'b1);
    pulse_start();
    repeat (10) @(negedge clk);
    bus.i_ch_en = 4'b1111;
    pulse_start();
    wait_idle();
    check("busy_start_strobes", n_rx - r0, 1);
    check("busy_start_cycles", busy_cyc - b0, 2 * SLOT);

    // 5: async reset after bit 5 rising edge of the second transfer
    bus.i_ch_en = 4'b0001; r0 = n_rx; s0 = n_sck;
    pulse_start();
    wait_evt(EV_SCK, s0 + DB + 6);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs",
             {bus.o_busy, bus.o_rx_dv, bus.o_convst, bus.o_sck, bus.o_serial_tx,
              bus.o_scan_done, bus.o_rx_ch, bus.o_rx_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_no_strobe", n_rx - r0, 0);
    b0 = busy_cyc; c0 = n_conv;
    push_exp(2'd0, 12'hA5C, 1'b1);
    pulse_start(); wait_idle();
    check("post_reset_conversions", n_conv - c0, 2);
    check("post_reset_busy_cycles", busy_cyc - b0, 2 * SLOT);

    // 6: mask/config changed mid-scan take effect only at the next start
    bus.i_ch_en = 4'b1111; bus.i_cfg = {6'h13, 6'h12, 6'h11, 6'h10};
    b0 = busy_cyc; c0 = n_conv;
    push_exp(2'd0, 12'h100, 1'b0);
    push_exp(2'd1, 12'h101, 1'b0);
    push_exp(2'd2, 12'h102, 1'b0);
    push_exp(2'd3, 12'h103, 1'b1);
    pulse_start();
    wait_evt(EV_CONV, c0 + 2);
    repeat (10) @(negedge clk);
    bus.i_ch_en = 4'b0001; bus.i_cfg = {4{6'h2D}};
    wait_idle();
    check("mask_change_busy_cycles", busy_cyc - b0, 5 * SLOT);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
